// File: rtl/vc_wrr_arbiter.sv
// vc_wrr_arbiter: weighted round-robin read scheduler that drains two VC fifos
// into one downstream fifo. VC0 wins ties from IDLE and owns W0 grants per turn.
// VC1 owns W1 grants per turn. Every read strobe produces exactly one registered
// word on data_out, two cycles after the strobe.
module vc_wrr_arbiter #(
  parameter int BW16 = 6,
  parameter int W0   = 4,
  parameter int W1   = 1,
  parameter int CW   = 4
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic            VC0_empty,
  input  logic            VC1_empty,
  input  logic [BW16-1:0] VC0_data_out,
  input  logic [BW16-1:0] VC1_data_out,
  input  logic            D_almost_full,
  output logic            VC0_rd,
  output logic            VC1_rd,
  output logic [BW16-1:0] data_out,
  output logic            valid_out,
  output logic            active_vc
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_e;

  localparam logic [CW-1:0] W0C  = CW'(W0);
  localparam logic [CW-1:0] W1C  = CW'(W1);
  localparam logic [CW-1:0] ONEC = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Read pipeline: stage 1 remembers which fifo was popped, stage 2 is the
  // registered word presented downstream.
  logic            rd_vld_q, rd_vld_d;
  logic            src_q, src_d;
  logic            valid_q, valid_d;
  logic            vc_q, vc_d;
  logic [BW16-1:0] data_q, data_d;

  // Both VC read ports as one packed array, indexed by the registered source.
  logic [1:0][BW16-1:0] vc_data;
  assign vc_data = {VC1_data_out, VC0_data_out};

  logic e0, e1;
  assign e0 = !VC0_empty && !D_almost_full;
  assign e1 = !VC1_empty && !D_almost_full;

  // FSM state and credit register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and credit: a turn ends on exhausted credit or an empty fifo;
  // an exhausted turn with the other VC empty simply refills the same VC.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (e0) begin
          state_d = SERVE0;
          cnt_d   = W0C;
        end else if (e1) begin
          state_d = SERVE1;
          cnt_d   = W1C;
        end
      end
      SERVE0: begin
        if (!D_almost_full) begin
          if (VC0_empty) begin
            // leftover credit is dropped
            if (!VC1_empty) begin
              state_d = SERVE1;
              cnt_d   = W1C;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else if (cnt_q > ONEC) begin
            cnt_d = cnt_q - ONEC;
          end else if (!VC1_empty) begin
            state_d = SERVE1;
            cnt_d   = W1C;
          end else begin
            cnt_d = W0C;
          end
        end
      end
      SERVE1: begin
        if (!D_almost_full) begin
          if (VC1_empty) begin
            if (!VC0_empty) begin
              state_d = SERVE0;
              cnt_d   = W0C;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else if (cnt_q > ONEC) begin
            cnt_d = cnt_q - ONEC;
          end else if (!VC0_empty) begin
            state_d = SERVE0;
            cnt_d   = W0C;
          end else begin
            cnt_d = W1C;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Read strobes: only the served VC may pop, and never while reset is held
  always_comb begin
    VC0_rd = reset_L && (state_q == SERVE0) && e0;
    VC1_rd = reset_L && (state_q == SERVE1) && e1;
  end

  // Datapath next values: capture the source at the strobe, then the fifo word
  // one cycle later; data_out and active_vc hold when nothing is delivered.
  always_comb begin
    rd_vld_d = VC0_rd || VC1_rd;
    src_d    = VC1_rd ? 1'b1 : (VC0_rd ? 1'b0 : src_q);
    valid_d  = rd_vld_q;
    data_d   = rd_vld_q ? vc_data[src_q] : data_q;
    vc_d     = rd_vld_q ? src_q : vc_q;
  end

  // Datapath registers; reset discards anything in flight
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd_vld_q <= 1'b0;
      src_q    <= 1'b0;
      valid_q  <= 1'b0;
      vc_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      rd_vld_q <= rd_vld_d;
      src_q    <= src_d;
      valid_q  <= valid_d;
      vc_q     <= vc_d;
      data_q   <= data_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active_vc = vc_q;

endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// Directed + random bench for vc_wrr_arbiter. Two behavioural fifos feed the
// DUT; each sampled read strobe pushes the expected word, VC and arrival cycle
// into a scoreboard that is checked against valid_out/data_out/active_vc.
module tb_vc_wrr_arbiter;
  localparam int BW = 6;
  localparam int W0 = 4;
  localparam int W1 = 1;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_L = 1'b1;
  logic          VC0_empty = 1'b1;
  logic          VC1_empty = 1'b1;
  logic [BW-1:0] VC0_data_out = '0;
  logic [BW-1:0] VC1_data_out = '0;
  logic          D_almost_full = 1'b0;
  logic          VC0_rd, VC1_rd, valid_out, active_vc;
  logic [BW-1:0] data_out;

  always #5 clk = ~clk;

  vc_wrr_arbiter #(.BW16(BW), .W0(W0), .W1(W1), .CW(CW)) dut (
    .clk(clk), .reset_L(reset_L),
    .VC0_empty(VC0_empty), .VC1_empty(VC1_empty),
    .VC0_data_out(VC0_data_out), .VC1_data_out(VC1_data_out),
    .D_almost_full(D_almost_full),
    .VC0_rd(VC0_rd), .VC1_rd(VC1_rd),
    .data_out(data_out), .valid_out(valid_out), .active_vc(active_vc)
  );

  typedef struct {
    int            vc;
    logic [BW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];
  int            rd_vc_log[$];
  int            rd_cyc_log[$];
  int            cyc = 0;
  int            tests = 0;
  int            fails = 0;
  int            vpulses = 0;
  logic [BW-1:0] seq0 = 6'h00;
  logic [BW-1:0] seq1 = 6'h20;
  int            pat[20] = '{0,0,0,0,1, 0,0,0,0,1, 0,0, 1,1,1,1,1,1,1,1};

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int vc, input int n);
    for (int i = 0; i < n; i++) begin
      if (vc == 0) begin q0.push_back(seq0); seq0 = seq0 + 1'b1; end
      else         begin q1.push_back(seq1); seq1 = seq1 + 1'b1; end
    end
    VC0_empty = (q0.size() == 0);
    VC1_empty = (q1.size() == 0);
  endtask

  // One clock: called at the falling edge; samples strobes/outputs, then models
  // the fifos popping on the rising edge.
  task automatic tick();
    logic r0, r1, ev;
    exp_t e;
    #1;
    r0 = VC0_rd;
    r1 = VC1_rd;
    check("rd_exclusive", int'(r0 & r1), 0);
    check("rd0_on_empty", int'(r0 & VC0_empty), 0);
    check("rd1_on_empty", int'(r1 & VC1_empty), 0);
    ev = (sb.size() > 0) && (sb[0].cyc == cyc);
    check("valid_out", int'(valid_out), int'(ev));
    if (valid_out) vpulses++;
    if (ev) begin
      e = sb.pop_front();
      if (valid_out) begin
        check("data_out", int'(data_out), int'(e.data));
        check("active_vc", int'(active_vc), e.vc);
      end
    end
    if (r0) begin
      rd_vc_log.push_back(0);
      rd_cyc_log.push_back(cyc);
      if (q0.size() > 0) begin e.vc = 0; e.data = q0[0]; e.cyc = cyc + 2; sb.push_back(e); end
    end
    if (r1) begin
      rd_vc_log.push_back(1);
      rd_cyc_log.push_back(cyc);
      if (q1.size() > 0) begin e.vc = 1; e.data = q1[0]; e.cyc = cyc + 2; sb.push_back(e); end
    end
    @(posedge clk);
    #1;
    if (r0 && q0.size() > 0) VC0_data_out = q0.pop_front();
    if (r1 && q1.size() > 0) VC1_data_out = q1.pop_front();
    VC0_empty = (q0.size() == 0);
    VC1_empty = (q1.size() == 0);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < maxc) begin
      tick();
      n++;
    end
    check("drain_timeout", int'(n < maxc), 1);
    repeat (3) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c0, c1;

    // reset state
    #1 reset_L = 1'b0;
    #1;
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_active_vc", int'(active_vc), 0);
    check("rst_rd0", int'(VC0_rd), 0);
    check("rst_rd1", int'(VC1_rd), 0);
    @(negedge clk);
    tick(); tick();
    reset_L = 1'b1;
    tick(); tick();

    // T1: three VC0 words, one IDLE cycle then three back-to-back reads
    push(0, 3);
    base = rd_vc_log.size(); c0 = cyc;
    drain(50);
    check("t1_rd_count", rd_vc_log.size() - base, 3);
    check("t1_first_rd", rd_cyc_log[base], c0 + 1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_vc%0d", i), rd_vc_log[base + i], 0);
      check($sformatf("t1_cyc%0d", i), rd_cyc_log[base + i], c0 + 1 + i);
    end

    // VC1 alone from IDLE
    push(1, 1);
    base = rd_vc_log.size(); c0 = cyc;
    drain(50);
    check("t1b_rd_count", rd_vc_log.size() - base, 1);
    check("t1b_vc", rd_vc_log[base], 1);
    check("t1b_cyc", rd_cyc_log[base], c0 + 1);

    // T2: 10 words each -> 0000 1 0000 1 00, bubble at VC0 empty, then VC1 run
    push(0, 10); push(1, 10);
    base = rd_vc_log.size(); c0 = cyc;
    drain(100);
    check("t2_rd_count", rd_vc_log.size() - base, 20);
    check("t2_first_rd", rd_cyc_log[base], c0 + 1);
    for (int i = 0; i < 20; i++)
      check($sformatf("t2_pat%0d", i), rd_vc_log[base + i], pat[i]);
    for (int i = 0; i < 11; i++)
      check($sformatf("t2_b2b%0d", i), rd_cyc_log[base + i + 1] - rd_cyc_log[base + i], 1);
    check("t2_switch_gap", rd_cyc_log[base + 12] - rd_cyc_log[base + 11], 2);

    // T3: backpressure for 5 cycles with 2 VC0 credits left
    push(0, 10); push(1, 10);
    base = rd_vc_log.size(); c0 = cyc;
    tick(); tick(); tick();
    check("t3_pre_rds", rd_vc_log.size() - base, 2);
    D_almost_full = 1'b1;
    vpulses = 0;
    repeat (5) tick();
    check("t3_no_rd_paused", rd_vc_log.size() - base, 2);
    check("t3_inflight", vpulses, 2);
    D_almost_full = 1'b0;
    drain(100);
    check("t3_resume_cyc", rd_cyc_log[base + 2], c0 + 8);
    check("t3_resume_vc_a", rd_vc_log[base + 2], 0);
    check("t3_resume_vc_b", rd_vc_log[base + 3], 0);
    check("t3_then_vc1", rd_vc_log[base + 4], 1);

    // T4: VC0 empties mid-turn, switch straight to VC1
    push(0, 1); push(1, 5);
    base = rd_vc_log.size(); c0 = cyc;
    drain(50);
    check("t4_rd_count", rd_vc_log.size() - base, 6);
    check("t4_vc0", rd_vc_log[base], 0);
    check("t4_vc0_cyc", rd_cyc_log[base], c0 + 1);
    check("t4_vc1_cyc", rd_cyc_log[base + 1], c0 + 3);
    for (int i = 1; i < 6; i++) begin
      check($sformatf("t4_vc%0d", i), rd_vc_log[base + i], 1);
      check($sformatf("t4_cyc%0d", i), rd_cyc_log[base + i], c0 + 2 + i);
    end

    // T5: async reset mid-burst drops in-flight words
    push(0, 8);
    repeat (4) tick();
    check("t5_pre_valid", int'(valid_out), 1);
    reset_L = 1'b0;
    #1;
    check("t5_valid_out", int'(valid_out), 0);
    check("t5_data_out", int'(data_out), 0);
    check("t5_active_vc", int'(active_vc), 0);
    check("t5_rd0_forced", int'(VC0_rd), 0);
    sb.delete();
    @(negedge clk);
    tick(); tick();
    reset_L = 1'b1;
    check("t5_left", q0.size(), 5);
    base = rd_vc_log.size(); c1 = cyc;
    drain(50);
    check("t5_restart_cyc", rd_cyc_log[base], c1 + 1);
    check("t5_rd_count", rd_vc_log.size() - base, 5);

    // T6: random pushes and backpressure
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0 && q0.size() < 16) push(0, 1);
      if ($urandom_range(0, 4) == 0 && q1.size() < 16) push(1, 1);
      if ($urandom_range(0, 9) == 0) D_almost_full = ~D_almost_full;
      tick();
    end
    D_almost_full = 1'b0;
    drain(500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
